// File: rtl/erasable_mem_arbiter.sv
// rtl/erasable_mem_arbiter.sv - erasable memory sequencer and arbiter for CPU and counter-increment ports
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata           CPU request (held until cpu_ack)
//   cpu_ack/rdata/err               CPU completion pulse, read data, blocked-write flag
//   cnt_req/dec/addr                counter request: PINC (dec=0) or MINC (dec=1)
//   cnt_ack/ovf/err                 counter completion pulse, overflow, illegal-address flag
//   mem_we/addr/wdata, mem_rdata    erasable memory array (combinational read)
module erasable_mem_arbiter #(
    parameter int          MAX_STEAL = 4,
    parameter logic [11:0] ZERO_ADDR = 12'd7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [11:0] cpu_addr,
    input  logic [14:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [14:0] cpu_rdata,
    output logic        cpu_err,
    input  logic        cnt_req,
    input  logic        cnt_dec,
    input  logic [11:0] cnt_addr,
    output logic        cnt_ack,
    output logic        cnt_ovf,
    output logic        cnt_err,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [14:0] mem_wdata,
    input  logic [14:0] mem_rdata
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CPU_ACC = 3'd1;
    localparam logic [2:0] S_CNT_RD  = 3'd2;
    localparam logic [2:0] S_CNT_WR  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam int         SW        = $clog2(MAX_STEAL + 1);
    localparam logic [SW-1:0] STEAL_MAX = SW'(MAX_STEAL);

    logic [2:0]    state;
    logic [SW-1:0] streak;
    logic [11:0]   addr_q;
    logic [14:0]   wdata_q;
    logic          we_q;
    logic          dec_q;
    logic          owner_cpu;
    logic [14:0]   x_q;
    logic [14:0]   rdata_q;
    logic          err_q;
    logic          ovf_q;

    logic grant_cnt;
    logic grant_cpu;
    logic addr_legal;

    // Counter wins ties until it has stolen MAX_STEAL cycles from a waiting CPU.
    assign grant_cnt  = (state == S_IDLE) && cnt_req && !(cpu_req && (streak == STEAL_MAX));
    assign grant_cpu  = (state == S_IDLE) && cpu_req && !grant_cnt;
    assign addr_legal = (addr_q[11:10] == 2'b00) && (addr_q != ZERO_ADDR);

    // Ones-complement increment/decrement with end-around carry.
    logic [14:0] addend;
    logic [15:0] sum;
    logic [14:0] fold;
    logic        arith_ovf;
    logic [14:0] result;

    assign addend    = dec_q ? 15'o77776 : 15'o00001;
    assign sum       = {1'b0, x_q} + {1'b0, addend};
    assign fold      = sum[14:0] + {14'd0, sum[15]};
    // Same-sign operands producing an opposite-sign result means the magnitude overflowed;
    // the counter then wraps to a signed zero matching the direction of travel.
    assign arith_ovf = (x_q[14] == addend[14]) && (fold[14] != x_q[14]);
    assign result    = arith_ovf ? {15{dec_q}} : fold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            streak    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            dec_q     <= 1'b0;
            owner_cpu <= 1'b0;
            x_q       <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (!cpu_req || grant_cpu) begin
                streak <= '0;
            end else if (grant_cnt && (streak != STEAL_MAX)) begin
                streak <= streak + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (grant_cnt) begin
                        addr_q    <= cnt_addr;
                        dec_q     <= cnt_dec;
                        we_q      <= 1'b1;
                        owner_cpu <= 1'b0;
                        state     <= S_CNT_RD;
                    end else if (grant_cpu) begin
                        addr_q    <= cpu_addr;
                        wdata_q   <= cpu_wdata;
                        we_q      <= cpu_we;
                        owner_cpu <= 1'b1;
                        state     <= S_CPU_ACC;
                    end
                end
                S_CPU_ACC: begin
                    rdata_q <= mem_rdata;
                    err_q   <= we_q && !addr_legal;
                    ovf_q   <= 1'b0;
                    state   <= S_DONE;
                end
                S_CNT_RD: begin
                    x_q   <= mem_rdata;
                    state <= S_CNT_WR;
                end
                S_CNT_WR: begin
                    err_q <= !addr_legal;
                    ovf_q <= addr_legal && arith_ovf;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = 12'd0;
        mem_wdata = 15'd0;
        case (state)
            S_CPU_ACC: begin
                mem_we    = we_q && addr_legal;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            S_CNT_RD: begin
                mem_addr = addr_q;
            end
            S_CNT_WR: begin
                mem_we    = addr_legal;
                mem_addr  = addr_q;
                mem_wdata = result;
            end
            default: ;
        endcase
    end

    assign cpu_ack   = (state == S_DONE) && owner_cpu;
    assign cnt_ack   = (state == S_DONE) && !owner_cpu;
    assign cpu_err   = cpu_ack && err_q;
    assign cnt_err   = cnt_ack && err_q;
    assign cnt_ovf   = cnt_ack && ovf_q;
    assign cpu_rdata = rdata_q;
endmodule

// File: tb/tb_erasable_mem_arbiter.sv
// tb/tb_erasable_mem_arbiter.sv - self-checking bench for erasable_mem_arbiter
module tb_erasable_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [11:0] cpu_addr;
    logic [14:0] cpu_wdata;
    logic        cpu_ack, cpu_err;
    logic [14:0] cpu_rdata;
    logic        cnt_req, cnt_dec;
    logic [11:0] cnt_addr;
    logic        cnt_ack, cnt_ovf, cnt_err;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [14:0] mem_wdata, mem_rdata;

    logic [14:0] mem [0:4095];
    logic        pl_we = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [14:0] pl_data = '0;

    int tests = 0;
    int fails = 0;
    int we_cycles = 0;

    typedef struct {
        logic [14:0] val;
        logic        flag;
        logic        err;
    } exp_t;
    exp_t sb[$];

    erasable_mem_arbiter #(.MAX_STEAL(4), .ZERO_ADDR(12'd7)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .cnt_req(cnt_req), .cnt_dec(cnt_dec), .cnt_addr(cnt_addr),
        .cnt_ack(cnt_ack), .cnt_ovf(cnt_ovf), .cnt_err(cnt_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    always @(negedge clk) if (mem_we) we_cycles++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [14:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic cpu_op(input string tag, input logic we, input logic [11:0] a,
                          input logic [14:0] d, input logic [14:0] exp_rd,
                          input logic exp_err, input int exp_we);
        exp_t e;
        int   lat = 0;
        int   we0 = we_cycles;
        sb.push_back('{exp_rd, exp_err, exp_err});
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                cpu_addr = 12'h0FF; cpu_wdata = 15'o55555; cpu_we = ~we;
            end
            if (cpu_ack) begin lat = i; break; end
        end
        cpu_req = 1'b0;
        e = sb.pop_front();
        chk({tag, " latency"}, lat, 2);
        if (lat != 0) begin
            if (!we) chk({tag, " rdata"}, cpu_rdata, e.val);
            chk({tag, " err"}, cpu_err, e.err);
            chk({tag, " we_cycles"}, we_cycles - we0, exp_we);
        end
        @(negedge clk);
    endtask

    task automatic cnt_op(input string tag, input logic dec, input logic [11:0] a,
                          input logic [14:0] init, input logic [14:0] exp_val,
                          input logic exp_ovf, input logic exp_err);
        exp_t e;
        int   lat = 0;
        preload(a, init);
        sb.push_back('{exp_val, exp_ovf, exp_err});
        cnt_dec = dec; cnt_addr = a; cnt_req = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin cnt_addr = 12'h0FE; cnt_dec = ~dec; end
            if (cnt_ack) begin lat = i; break; end
        end
        cnt_req = 1'b0;
        e = sb.pop_front();
        chk({tag, " latency"}, lat, 3);
        if (lat != 0) begin
            chk({tag, " value"}, mem[a], e.val);
            chk({tag, " ovf"}, cnt_ovf, e.flag);
            chk({tag, " err"}, cnt_err, e.err);
        end
        @(negedge clk);
    endtask

    initial begin
        string order;
        int    t_cnt, t_cpu, acks, got_ack;
        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        cnt_req = 0; cnt_dec = 0; cnt_addr = '0;
        repeat (2) @(negedge clk);
        chk("reset ack", {cpu_ack, cnt_ack, cpu_err, cnt_err, cnt_ovf}, 0);
        chk("reset mem", {mem_we, mem_addr, mem_wdata}, 0);
        chk("reset rdata", cpu_rdata, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // CPU write/read and blocked writes
        cpu_op("wr010", 1'b1, 12'h010, 15'o12345, 15'o0, 1'b0, 1);
        cpu_op("rd010", 1'b0, 12'h010, 15'o0, 15'o12345, 1'b0, 0);
        preload(12'h007, 15'o00111);
        preload(12'h400, 15'o00222);
        cpu_op("wr007", 1'b1, 12'h007, 15'o77777, 15'o0, 1'b1, 0);
        cpu_op("wr400", 1'b1, 12'h400, 15'o77777, 15'o0, 1'b1, 0);
        chk("mem007 kept", mem[12'h007], 15'o00111);
        chk("mem400 kept", mem[12'h400], 15'o00222);
        cpu_op("rd007", 1'b0, 12'h007, 15'o0, 15'o00111, 1'b0, 0);

        // Counter arithmetic
        cnt_op("pinc5",   1'b0, 12'h020, 15'o00005, 15'o00006, 1'b0, 1'b0);
        cnt_op("pinc37k", 1'b0, 12'h020, 15'o37777, 15'o00000, 1'b1, 1'b0);
        cnt_op("pincm0",  1'b0, 12'h020, 15'o77777, 15'o00001, 1'b0, 1'b0);
        cnt_op("minc40k", 1'b1, 12'h020, 15'o40000, 15'o77777, 1'b1, 1'b0);
        cnt_op("minc0",   1'b1, 12'h020, 15'o00000, 15'o77776, 1'b0, 1'b0);
        cnt_op("cntill",  1'b0, 12'h400, 15'o37777, 15'o37777, 1'b0, 1'b1);
        cnt_op("cntzero", 1'b1, 12'h007, 15'o00003, 15'o00003, 1'b0, 1'b1);

        // Simultaneous first requests: counter first, CPU one IDLE cycle after its ack
        preload(12'h030, 15'o00000);
        cpu_we = 0; cpu_addr = 12'h010; cnt_dec = 0; cnt_addr = 12'h030;
        cpu_req = 1; cnt_req = 1;
        t_cnt = 0; t_cpu = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (cnt_ack) begin t_cnt = i; cnt_req = 0; end
            if (cpu_ack) begin t_cpu = i; cpu_req = 0; break; end
        end
        cpu_req = 0; cnt_req = 0;
        chk("sim cnt first", t_cnt, 3);
        chk("sim cpu after", t_cpu, 6);
        @(negedge clk);

        // Both held continuously: starvation bound
        order = "";
        acks = 0;
        cpu_req = 1; cnt_req = 1;
        for (int i = 0; i < 200 && acks < 10; i++) begin
            @(negedge clk);
            if (cnt_ack) begin order = {order, "C"}; acks++; end
            if (cpu_ack) begin order = {order, "P"}; acks++; end
        end
        cpu_req = 0; cnt_req = 0;
        chk("arb ack count", acks, 10);
        chk("arb order 0-4", (order.substr(0, 4) == "CCCCP") ? 1 : 0, 1);
        chk("arb order 5-9", (order.substr(5, 9) == "CCCCP") ? 1 : 0, 1);
        repeat (2) @(negedge clk);

        // Reset in the middle of CNT_WR
        preload(12'h020, 15'o00005);
        cnt_dec = 0; cnt_addr = 12'h020; cnt_req = 1;
        repeat (2) @(negedge clk);
        chk("rst pre we", mem_we, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk("rst async we", mem_we, 1'b0);
        cnt_req = 0;
        got_ack = 0;
        repeat (3) begin
            @(negedge clk);
            if (cnt_ack || cpu_ack) got_ack = 1;
        end
        chk("rst no ack", got_ack, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst mem kept", mem[12'h020], 15'o00005);
        cpu_op("rst rd020", 1'b0, 12'h020, 15'o0, 15'o00005, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
